// File: rtl/layer_norm_pkg.sv
// ============================================================================
// layer_norm_pkg : shared types and constants for the layer-norm engine
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package layer_norm_pkg;

    localparam int ACC_WIDTH  = 32;
    localparam int NR_ITERS   = 4;
    localparam int ITER_WIDTH = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_MEAN    = 3'd2,
        ST_VAR     = 3'd3,
        ST_SQRT    = 3'd4,
        ST_NORM    = 3'd5,
        ST_DONE    = 3'd6
    } ln_state_e;

    // Divide-by-EMBED_DIM is a right shift, so the length must be a power of two.
    function automatic int calc_shift(input int embed_dim);
        return $clog2(embed_dim);
    endfunction

endpackage

`default_nettype wire

// File: rtl/layer_norm_isqrt_step.sv
// ============================================================================
// layer_norm_isqrt_step : one combinational Newton-Raphson integer sqrt step
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_norm_isqrt_step
    import layer_norm_pkg::*;
(
    input  logic signed [ACC_WIDTH-1:0] i_variance,
    input  logic signed [ACC_WIDTH-1:0] i_std,
    output logic signed [ACC_WIDTH-1:0] o_std
);

    logic signed [ACC_WIDTH-1:0] w_divisor;
    logic signed [ACC_WIDTH-1:0] w_quot;
    logic signed [ACC_WIDTH-1:0] w_sum;

    // Divisor is forced non-zero so the unused branch never divides by zero.
    assign w_divisor = (i_std == '0) ? ACC_WIDTH'(1) : i_std;
    assign w_quot    = i_variance / w_divisor;
    assign w_sum     = i_std + w_quot;
    assign o_std     = (i_std == '0) ? '0 : (w_sum >>> 1);

endmodule

`default_nettype wire

// File: rtl/layer_norm1.sv
// ============================================================================
// layer_norm1 : integer layer normalisation (mean, variance, NR sqrt, divide)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_norm1
    import layer_norm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int EMBED_DIM  = 8
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         layernorm_start,
    input  logic signed [DATA_WIDTH-1:0] activation_in  [EMBED_DIM],
    output logic                         layernorm_done,
    output logic signed [DATA_WIDTH-1:0] normalized_out [EMBED_DIM]
);

    localparam int c_shift = calc_shift(EMBED_DIM);

    ln_state_e                   r_state;
    logic signed [DATA_WIDTH-1:0] r_x [EMBED_DIM];
    logic signed [ACC_WIDTH-1:0] r_sum;
    logic signed [ACC_WIDTH-1:0] r_mean;
    logic signed [ACC_WIDTH-1:0] r_variance;
    logic signed [ACC_WIDTH-1:0] r_std;
    logic [ITER_WIDTH-1:0]       r_iter;

    logic signed [ACC_WIDTH-1:0] w_x_ext [EMBED_DIM];
    logic signed [ACC_WIDTH-1:0] w_diff  [EMBED_DIM];
    logic signed [ACC_WIDTH-1:0] w_sq    [EMBED_DIM];
    logic signed [DATA_WIDTH-1:0] w_norm [EMBED_DIM];
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_sum_sq;
    logic signed [ACC_WIDTH-1:0] w_var_new;
    logic signed [ACC_WIDTH-1:0] w_std_next;
    logic signed [ACC_WIDTH-1:0] w_div_std;

    assign w_div_std = (r_std == '0) ? ACC_WIDTH'(1) : r_std;

    for (genvar gi = 0; gi < EMBED_DIM; gi++) begin : g_elem
        assign w_x_ext[gi] = {{(ACC_WIDTH-DATA_WIDTH){r_x[gi][DATA_WIDTH-1]}}, r_x[gi]};
        assign w_diff[gi]  = w_x_ext[gi] - r_mean;
        assign w_sq[gi]    = w_diff[gi] * w_diff[gi];
        // SV signed division truncates toward zero; result wraps to DATA_WIDTH.
        assign w_norm[gi]  = (r_std == '0) ? '0 : DATA_WIDTH'(w_diff[gi] / w_div_std);
    end

    always_comb begin
        w_sum    = '0;
        w_sum_sq = '0;
        for (int i = 0; i < EMBED_DIM; i++) begin
            w_sum    = w_sum + w_x_ext[i];
            w_sum_sq = w_sum_sq + w_sq[i];
        end
    end

    assign w_var_new = w_sum_sq >>> c_shift;

    layer_norm_isqrt_step u_isqrt_step (
        .i_variance (r_variance),
        .i_std      (r_std),
        .o_std      (w_std_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            layernorm_done <= 1'b0;
            r_sum          <= '0;
            r_mean         <= '0;
            r_variance     <= '0;
            r_std          <= '0;
            r_iter         <= '0;
            for (int i = 0; i < EMBED_DIM; i++) begin
                r_x[i]            <= '0;
                normalized_out[i] <= '0;
            end
        end else begin
            layernorm_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (layernorm_start) begin
                        for (int i = 0; i < EMBED_DIM; i++) begin
                            r_x[i] <= activation_in[i];
                        end
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_sum   <= w_sum;
                    r_state <= ST_MEAN;
                end
                ST_MEAN: begin
                    // Arithmetic shift floors negative sums (-57 -> -8).
                    r_mean  <= r_sum >>> c_shift;
                    r_state <= ST_VAR;
                end
                ST_VAR: begin
                    r_variance <= w_var_new;
                    r_std      <= w_var_new >>> 1;
                    r_iter     <= '0;
                    r_state    <= ST_SQRT;
                end
                ST_SQRT: begin
                    // Fixed iteration count, no convergence exit: keeps results bit-exact.
                    r_std  <= w_std_next;
                    r_iter <= r_iter + ITER_WIDTH'(1);
                    if (r_iter == ITER_WIDTH'(NR_ITERS - 1)) begin
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    for (int i = 0; i < EMBED_DIM; i++) begin
                        normalized_out[i] <= w_norm[i];
                    end
                    layernorm_done <= 1'b1;
                    r_state        <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_layer_norm1.sv
// ============================================================================
// tb_layer_norm1 : directed-vector bench for layer_norm1
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer_norm1;

    localparam int DW = 16;
    localparam int ED = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 layernorm_start;
    logic signed [DW-1:0] activation_in  [ED];
    logic                 layernorm_done;
    logic signed [DW-1:0] normalized_out [ED];

    int n_vec        = 0;
    int n_miscompare = 0;
    int stim    [ED];
    int exp_out [ED];
    int lat;
    int n_done;

    always #5 clk = ~clk;

    layer_norm1 #(
        .DATA_WIDTH (DW),
        .EMBED_DIM  (ED)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .layernorm_start (layernorm_start),
        .activation_in   (activation_in),
        .layernorm_done  (layernorm_done),
        .normalized_out  (normalized_out)
    );

    task automatic check(input string tag, input int observed, input int expected);
        n_vec++;
        if (observed !== expected) begin
            n_miscompare++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_stim();
        for (int i = 0; i < ED; i++) activation_in[i] = DW'(stim[i]);
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < ED; i++)
            check($sformatf("%s out[%0d]", tag, i), int'(normalized_out[i]), exp_out[i]);
    endtask

    task automatic check_internals(input string tag, input int m, input int v, input int s);
        check({tag, " mean"}, int'(dut.r_mean), m);
        check({tag, " variance"}, int'(dut.r_variance), v);
        check({tag, " std"}, int'(dut.r_std), s);
    endtask

    // Start edge is cycle 0; sample after it is cycle 1, done expected in cycle 9.
    task automatic run_op(input string tag, input bit scramble);
        load_stim();
        layernorm_start = 1'b1;
        step();
        layernorm_start = 1'b0;
        if (scramble)
            for (int i = 0; i < ED; i++) activation_in[i] = DW'(16'sh7123 + i);
        lat = 1;
        while (layernorm_done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check({tag, " latency"}, lat, 9);
    endtask

    task automatic count_dones(input int cycles);
        n_done = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (layernorm_done === 1'b1) n_done++;
        end
    endtask

    initial begin
        rst             = 1'b1;
        layernorm_start = 1'b0;
        for (int i = 0; i < ED; i++) activation_in[i] = '0;
        step(); step(); step();
        rst = 1'b0;
        check("reset done", int'(layernorm_done), 0);
        exp_out = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_outputs("reset");

        // Mixed vector
        stim    = '{5, 3, 3, 4, -1, 0, 2, 9};
        exp_out = '{1, 0, 0, 0, -2, -1, 0, 3};
        run_op("mixed", 1'b0);
        check_internals("mixed", 3, 8, 2);
        check_outputs("mixed");
        step();
        check("mixed done width", int'(layernorm_done), 0);

        // Constant vector
        stim    = '{50, 50, 50, 50, 50, 50, 50, 50};
        exp_out = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_op("const", 1'b0);
        check_internals("const", 50, 0, 0);
        check_outputs("const");
        step();

        // Negative floor mean
        stim    = '{-8, -8, -8, -8, -8, -8, -8, -1};
        exp_out = '{0, 0, 0, 0, 0, 0, 0, 3};
        run_op("negmean", 1'b0);
        check_internals("negmean", -8, 6, 2);
        check_outputs("negmean");
        step();

        // Large spread
        stim    = '{16, -16, 16, -16, 16, -16, 16, -16};
        exp_out = '{1, -1, 1, -1, 1, -1, 1, -1};
        run_op("spread", 1'b0);
        check_internals("spread", 0, 256, 16);
        check_outputs("spread");
        step();

        // Start pulsed while in SQRT is ignored; old outputs held until done
        stim = '{5, 3, 3, 4, -1, 0, 2, 9};
        load_stim();
        layernorm_start = 1'b1;
        step();
        layernorm_start = 1'b0;
        lat = 1;
        while (layernorm_done !== 1'b1 && lat < 40) begin
            step();
            lat++;
            if (lat == 5) begin
                layernorm_start = 1'b1;
                for (int i = 0; i < ED; i++) activation_in[i] = DW'(50);
            end
            if (lat == 6) layernorm_start = 1'b0;
            if (lat == 7) check_outputs("held");
        end
        check("busy-start latency", lat, 9);
        exp_out = '{1, 0, 0, 0, -2, -1, 0, 3};
        check_outputs("busy-start");
        count_dones(15);
        check("busy-start extra dones", n_done, 0);

        // Reset in VAR aborts: no done, outputs cleared
        stim = '{-8, -8, -8, -8, -8, -8, -8, -1};
        load_stim();
        layernorm_start = 1'b1;
        step();
        layernorm_start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_dones(15);
        check("abort dones", n_done, 0);
        exp_out = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_outputs("abort");

        // Next start after abort completes normally
        exp_out = '{0, 0, 0, 0, 0, 0, 0, 3};
        run_op("post-abort", 1'b0);
        check_internals("post-abort", -8, 6, 2);
        check_outputs("post-abort");
        step();

        // Input changed after accepting edge has no effect
        stim    = '{5, 3, 3, 4, -1, 0, 2, 9};
        exp_out = '{1, 0, 0, 0, -2, -1, 0, 3};
        run_op("isolate", 1'b1);
        check_internals("isolate", 3, 8, 2);
        check_outputs("isolate");
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/layer_norm1.md
Name: layer_norm1

Overview:
Integer layer-normalisation engine for one token vector of EMBED_DIM signed activations, used in the transformer (MobileViT) block datapath. On a start pulse it computes the following, bit-exactly:
- mean
- population variance
- Newton–Raphson integer square root of the variance (std)
- (x−mean)/std per element

It then pulses done. There is no gamma/beta scaling.

Parameters:
DATA_WIDTH, 16, width of each signed activation and output element
EMBED_DIM, 8, vector length; must be a power of two, ≥2

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
layernorm_start  in  1  start pulse; sampled only in IDLE
activation_in  in  EMBED_DIM x DATA_WIDTH (signed, unpacked array)  input vector; captured on the accepting edge
layernorm_done  out  1  one-cycle completion pulse
normalized_out  out  EMBED_DIM x DATA_WIDTH (signed, unpacked array)  normalised result; held until next completion

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset: state=IDLE, layernorm_done=0, normalized_out all 0, internal registers 0. Reset mid-operation aborts the computation; no done pulse follows.
- Arithmetic: all intermediates are signed and at least 32 bits wide (behave as 32-bit signed integers); no saturation.
- FSM states: IDLE, CAPTURE, MEAN, VAR, SQRT, NORM, DONE.
- IDLE: if layernorm_start=1, register activation_in into x[], go to CAPTURE. Otherwise stay.
- CAPTURE: sum = Σx[i]; go to MEAN.
- MEAN: mean = sum >>> log2(EMBED_DIM). This is an arithmetic shift (floor division), e.g. sum −57 → mean −8. Go to VAR.
- VAR:
  - sum_sq = Σ(x[i]−mean)².
  - variance = sum_sq >>> log2(EMBED_DIM).
  - std = variance >>> 1 (initial guess).
  - iter = 0; go to SQRT.
- SQRT: exactly 4 iterations, one per cycle.
  - Each cycle: if std≠0 then std = (std + variance/std) >>> 1; the division truncates.
  - iter++.
  - After the 4th iteration go to NORM.
  - The iteration count is fixed; there is no early exit and no convergence check. Keep this for bit-exactness: variance 8 → std 2; variance 1 → std 0.
- NORM: normalized_out[i] = (std≠0) ? (x[i]−mean)/std : 0.
  - Signed division truncates toward zero (−1/2=0, −4/2=−2).
  - The result is truncated to DATA_WIDTH.
  - Go to DONE.
- DONE: layernorm_done=1 for exactly this cycle; go to IDLE.
- Latency: done is high in the 9th cycle after the accepting edge (1 capture + mean + var + 4 sqrt + norm, then DONE).
- layernorm_start while not in IDLE is ignored. Start held high through DONE re-triggers in the next IDLE cycle.
- activation_in may change after the accepting edge without affecting the result.
- normalized_out is stable from the DONE cycle until the next NORM.

Decomposition:
- Shared package (layer_norm_pkg):
  - state enum
  - ACC_WIDTH=32 constant
  - NR_ITERS=4 constant
  - localparam helper for SHIFT = $clog2(EMBED_DIM)
- One sub-module, layer_norm_isqrt_step: combinational single Newton step (variance, std_in → std_out, with the zero guard), instantiated once and iterated by the FSM.
- Element-wise sum, variance and divide remain generate loops in the top.

Test Plan:
- Mixed vector:
  - Stimulus: {5,3,3,4,−1,0,2,9}.
  - Required internals: mean 3, variance 8, std 2.
  - Required out: {1,0,0,0,−2,−1,0,3}.
  - Done exactly 9 cycles after the start edge, one cycle wide.
- Constant vector:
  - Stimulus: {50 x8}.
  - Required: variance 0, std 0, all outputs 0, done still pulses.
- Negative floor mean:
  - Stimulus: {−8,−8,−8,−8,−8,−8,−8,−1}.
  - Required: mean −8, variance 6, std 2.
  - Required out: {0,0,0,0,0,0,0,3}.
- Large spread:
  - Stimulus: {16,−16,16,−16,16,−16,16,−16}.
  - Required: mean 0, variance 256, std 16.
  - Required out: {1,−1,1,−1,1,−1,1,−1}.
- Handshake and reset:
  - Start pulsed during SQRT → ignored; exactly one done; outputs unchanged until that done.
  - rst asserted during VAR → no done; outputs 0.
  - Next start completes normally.
- Input isolation: change activation_in the cycle after start → result matches the captured vector.
